// File: rtl/calc_pkg.sv
// Shared types and constants for the calc_core multiply/serialize block.
package calc_pkg;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_SAT, S_SEND} calc_state_t;

    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned OUT_BYTES_DEF = 4;

    localparam logic [DATA_W_DEF-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [DATA_W_DEF-1:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/calc_if.sv
// Loader-facing operand/request and byte-stream result signals of calc_core.
interface calc_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] a0;
    logic [DATA_W-1:0] a1;
    logic              start_calc;
    logic              core_busy;
    logic [7:0]        out_pins;
    logic              out_valid;
    logic              out_last;
    logic              ovf;

    modport master (
        output a0, a1, start_calc,
        input  core_busy, out_pins, out_valid, out_last, ovf
    );

    modport slave (
        input  a0, a1, start_calc,
        output core_busy, out_pins, out_valid, out_last, ovf
    );
endinterface

// File: rtl/seq_mult.sv
// Unsigned DATA_W x DATA_W shift-add multiplier, one partial product per cycle.
module seq_mult #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                done,
    output logic [2*DATA_W-1:0] product
);
    localparam int unsigned CntW = $clog2(DATA_W);
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                run_q, run_d;

    always_comb begin
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (load) begin
            mcand_d  = {{DATA_W{1'b0}}, a};
            mplier_d = b;
            prod_d   = '0;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

    // High during the cycle whose closing edge performs the final iteration.
    assign done    = run_q && (cnt_q == CntLast);
    assign product = prod_q;

endmodule

// File: rtl/calc_core.sv
// Signed multiply with 32-bit saturation; result streamed LSB byte first.
module calc_core
    import calc_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned OUT_BYTES = OUT_BYTES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    calc_if.slave bus
);
    localparam int unsigned BcW = $clog2(OUT_BYTES + 1);
    localparam logic [2*DATA_W-1:0] PosLim = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic [2*DATA_W-1:0] NegLim = {{DATA_W{1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]   SatMax = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]   SatMin = {1'b1, {(DATA_W-1){1'b0}}};

    calc_state_t state_q, state_d;
    logic        start_d_q;
    logic        sign_q, sign_d;
    logic        busy_q, busy_d;
    logic [7:0]  out_pins_q, out_pins_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic        ovf_q, ovf_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [BcW-1:0]    byte_cnt_q, byte_cnt_d;

    logic                accept;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic                mult_done;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   sat_val;
    logic                sat_ovf;
    logic [DATA_W-1:0]   res_shift;

    // Magnitude of the most negative value wraps to 2^(DATA_W-1), which is correct unsigned.
    assign a_mag = bus.a0[DATA_W-1] ? (~bus.a0 + 1'b1) : bus.a0;
    assign b_mag = bus.a1[DATA_W-1] ? (~bus.a1 + 1'b1) : bus.a1;

    assign accept    = (state_q == S_IDLE) && bus.start_calc && !start_d_q;
    assign res_shift = res_q >> {byte_cnt_q, 3'b000};

    seq_mult #(
        .DATA_W (DATA_W)
    ) u_seq_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .a       (a_mag),
        .b       (b_mag),
        .done    (mult_done),
        .product (prod)
    );

    always_comb begin
        sat_ovf = 1'b0;
        sat_val = prod[DATA_W-1:0];
        if (sign_q) begin
            if (prod > NegLim) begin
                sat_val = SatMin;
                sat_ovf = 1'b1;
            end else begin
                sat_val = ~prod[DATA_W-1:0] + 1'b1;
            end
        end else if (prod > PosLim) begin
            sat_val = SatMax;
            sat_ovf = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        busy_d      = busy_q;
        out_pins_d  = out_pins_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        ovf_d       = ovf_q;
        res_d       = res_q;
        byte_cnt_d  = byte_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sign_d  = bus.a0[DATA_W-1] ^ bus.a1[DATA_W-1];
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (mult_done) begin
                    state_d = S_SAT;
                end
            end
            S_SAT: begin
                res_d       = sat_val;
                ovf_d       = sat_ovf;
                out_pins_d  = sat_val[7:0];
                out_valid_d = 1'b1;
                out_last_d  = (OUT_BYTES == 1);
                byte_cnt_d  = BcW'(1);
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (byte_cnt_q == BcW'(OUT_BYTES)) begin
                    out_pins_d  = '0;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    out_pins_d = res_shift[7:0];
                    out_last_d = (byte_cnt_q == BcW'(OUT_BYTES - 1));
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            start_d_q   <= 1'b0;
            sign_q      <= 1'b0;
            busy_q      <= 1'b0;
            out_pins_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            ovf_q       <= 1'b0;
            res_q       <= '0;
            byte_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            start_d_q   <= bus.start_calc;
            sign_q      <= sign_d;
            busy_q      <= busy_d;
            out_pins_q  <= out_pins_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            ovf_q       <= ovf_d;
            res_q       <= res_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    assign bus.core_busy = busy_q;
    assign bus.out_pins  = out_pins_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_calc_core.sv
// Self-checking bench for calc_core: vector table, random jobs vs. arithmetic model, corner sequences.
module tb_calc_core;
    import calc_pkg::*;

    typedef struct {
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    calc_if #(.DATA_W(32)) bus ();

    calc_core #(
        .DATA_W    (32),
        .OUT_BYTES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Signed product in 64-bit arithmetic, then clamp to the 32-bit signed range.
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic o);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        o = 1'b0;
        if (p > 64'sd2147483647) begin
            r = SAT_MAX;
            o = 1'b1;
        end else if (p < -64'sd2147483648) begin
            r = SAT_MIN;
            o = 1'b1;
        end else begin
            r = p[31:0];
        end
    endfunction

    // mode 0: drop start after accept; 1: hold start; 2: extra edge + operand change mid-multiply.
    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input int mode,
                           output logic [31:0] res, output logic o, output int busy_cyc,
                           output int first_n, output int nbytes, output int last_n,
                           output int stray);
        res = '0; busy_cyc = 0; first_n = -1; nbytes = 0; last_n = -1; stray = 0;
        @(negedge clk);
        bus.a0 = a;
        bus.a1 = b;
        bus.start_calc = 1'b1;
        @(posedge clk); #1;
        if (bus.core_busy) busy_cyc = 1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (mode == 0 && n == 1) bus.start_calc = 1'b0;
            if (mode == 2) begin
                if (n == 5) bus.start_calc = 1'b0;
                if (n == 6) bus.start_calc = 1'b1;
                if (n == 10) begin
                    bus.a0 = $urandom;
                    bus.a1 = $urandom;
                end
            end
            @(posedge clk); #1;
            if (bus.core_busy) busy_cyc++;
            if (bus.out_valid) begin
                if (nbytes < 4) res[8*nbytes +: 8] = bus.out_pins;
                if (nbytes == 0) first_n = n;
                if (bus.out_last) last_n = n;
                nbytes++;
            end else if (bus.out_pins != 8'h00 || bus.out_last) begin
                stray++;
            end
            if (!bus.core_busy) break;
        end
        o = bus.ovf;
    endtask

    task automatic job_and_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                                 input int mode, input logic [31:0] exp_res, input logic exp_ovf,
                                 input bit timing);
        logic [31:0] res;
        logic        o;
        int          busy_cyc, first_n, nbytes, last_n, stray;
        run_job(a, b, mode, res, o, busy_cyc, first_n, nbytes, last_n, stray);
        check({tag, " result"}, 64'(res), 64'(exp_res));
        check({tag, " ovf"}, 64'(o), 64'(exp_ovf));
        check({tag, " byte count"}, 64'(nbytes), 64'd4);
        if (timing) begin
            check({tag, " busy cycles"}, 64'(busy_cyc), 64'd37);
            check({tag, " first byte latency"}, 64'(first_n), 64'd33);
            check({tag, " last flag position"}, 64'(last_n), 64'd36);
            check({tag, " idle pins nonzero"}, 64'(stray), 64'd0);
        end
    endtask

    task automatic idle_watch(input string tag, input int cycles);
        int busy_seen = 0;
        int valid_seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bus.core_busy) busy_seen++;
            if (bus.out_valid) valid_seen++;
        end
        check({tag, " busy while idle"}, 64'(busy_seen), 64'd0);
        check({tag, " bytes while idle"}, 64'(valid_seen), 64'd0);
    endtask

    vec_t vecs[10];

    initial begin
        logic [31:0] ra, rb, er;
        logic        eo;
        int          sel;

        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        bus.a0 = '0;
        bus.a1 = '0;
        bus.start_calc = 1'b0;
        #23;
        check("reset outputs", 64'({bus.core_busy, bus.out_valid, bus.out_last, bus.ovf,
                                    bus.out_pins}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        vecs[0] = '{32'd3,          32'hFFFF_FFFB, 32'hFFFF_FFF1, 1'b0};
        vecs[1] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
        vecs[2] = '{32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000, 1'b1};
        vecs[3] = '{32'd0,          32'h7FFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1};
        vecs[6] = '{32'h0001_0000, 32'h0000_8000, 32'h7FFF_FFFF, 1'b1};
        vecs[7] = '{32'hFFFF_0000, 32'h0000_8000, 32'h8000_0000, 1'b0};
        vecs[8] = '{32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF, 1'b0};
        vecs[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};

        // Consecutive jobs leave a single idle cycle between busy periods.
        for (int i = 0; i < 10; i++) begin
            job_and_check($sformatf("vec%0d", i), vecs[i].a0, vecs[i].a1, 0,
                          vecs[i].res, vecs[i].ovf, 1'b1);
        end

        for (int i = 0; i < 20; i++) begin
            sel = $urandom_range(0, 2);
            if (sel == 0) begin
                ra = $urandom;
                rb = $urandom;
            end else if (sel == 1) begin
                ra = 32'($signed($urandom_range(0, 2000)) - 1000);
                rb = 32'($signed($urandom_range(0, 2000)) - 1000);
            end else begin
                ra = 32'($signed($urandom_range(0, 131072)) - 65536);
                rb = 32'($signed($urandom_range(0, 131072)) - 65536);
            end
            ref_model(ra, rb, er, eo);
            job_and_check($sformatf("rand%0d", i), ra, rb, 0, er, eo, (i % 5) == 0);
        end

        // Start held high well beyond job end: one job only, then a fresh edge runs again.
        job_and_check("held start", 32'd5, 32'd7, 1, 32'd35, 1'b0, 1'b1);
        idle_watch("held start", 63);
        @(negedge clk);
        bus.start_calc = 1'b0;
        job_and_check("after release", 32'hFFFF_FFF9, 32'd9, 0, 32'hFFFF_FFC1, 1'b0, 1'b1);

        // Extra start edge and operand change while multiplying must not disturb the job.
        ref_model(32'h0012_3456, 32'hFFFF_FF00, er, eo);
        job_and_check("mid-job poke", 32'h0012_3456, 32'hFFFF_FF00, 2, er, eo, 1'b1);
        idle_watch("mid-job poke", 10);
        @(negedge clk);
        bus.start_calc = 1'b0;

        // Reset asserted while byte 2 of an overflowing job is on the pins.
        begin
            int n_hit = 0;
            @(negedge clk);
            bus.a0 = 32'h8000_0000;
            bus.a1 = 32'h8000_0000;
            bus.start_calc = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            bus.start_calc = 1'b0;
            for (int n = 1; n <= 35; n++) begin
                if (n > 1) @(negedge clk);
                @(posedge clk); #1;
                if (n == 35 && bus.out_valid && bus.ovf) n_hit = 1;
            end
            check("reset seq byte2 in flight", 64'(n_hit), 64'd1);
            #2;
            rst_n = 1'b0;
            #1;
            check("reset mid-send outputs", 64'({bus.core_busy, bus.out_valid, bus.out_last,
                                                 bus.ovf, bus.out_pins}), 64'd0);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            idle_watch("post reset", 45);
        end

        job_and_check("zero operand", 32'd0, 32'h7FFF_FFFF, 0, 32'd0, 1'b0, 1'b1);
        job_and_check("back-to-back", 32'd3, 32'hFFFF_FFFB, 0, 32'hFFFF_FFF1, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
